tx_distributor: RTL and testbench

TX_DISTRIBUTOR -- requirements
Module: tx_distributor

---
 rtl/tx_distributor_pkg.sv | 17 +
 rtl/tx_distributor.sv | 127 ++++++++++++
 tb/tb_tx_distributor.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_distributor_pkg.sv
// Shared constants and FSM encoding for the 25G PCS transmit distributor.
// Lane geometry, SYNC tag value and distributor states live here.
package tx_distributor_pkg;

  localparam int unsigned UNITWIDTH  = 48;
  localparam int unsigned LANENUMBER = 4;
  localparam int unsigned DATAWIDTH  = UNITWIDTH * LANENUMBER;

  localparam logic [15:0] SYNC_TAG = 16'hB5A7;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DRAIN     = 2'd1,
    ST_SEND_SYNC = 2'd2
  } dist_state_e;

endpackage

// File: rtl/tx_distributor.sv
// Holds one upstream word and feeds the swizzler, inserting a SYNC word
// every cfg_sync_interval data words or whenever local block-lock changes.
module tx_distributor
  import tx_distributor_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_enable,
  input  logic [DATAWIDTH-1:0]  in_data,
  input  logic                  in_data_valid,
  output logic                  out_ready,
  input  logic [LANENUMBER-1:0] in_local_blocklock,
  input  logic [15:0]           cfg_sync_interval,
  input  logic                  in_idle,
  input  logic                  in_empty,
  output logic [DATAWIDTH-1:0]  out_txdata,
  output logic                  out_txdata_valid,
  output logic                  out_syncing_pre
);

  dist_state_e           r_state;
  logic [DATAWIDTH-1:0]  r_buf;
  logic                  r_buf_full;
  logic [15:0]           r_cnt;
  logic                  r_sync_req;
  logic [LANENUMBER-1:0] r_bl_copy;
  logic [LANENUMBER-1:0] r_bl_snap;

  logic w_xfer;
  logic w_acc;
  logic w_sync_due;
  logic w_bl_change;

  function automatic logic [DATAWIDTH-1:0] build_sync(input logic [LANENUMBER-1:0] bl);
    logic [DATAWIDTH-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < LANENUMBER; i++) begin
      w[i*UNITWIDTH +: UNITWIDTH] = {SYNC_TAG, {(UNITWIDTH-16-LANENUMBER){1'b0}}, bl};
    end
    return w;
  endfunction

  always_comb begin
    w_xfer      = (r_state == ST_RUN) && r_buf_full && in_idle && in_enable;
    // ">=" so a lowered interval still fires at the next transfer
    w_sync_due  = (cfg_sync_interval != '0) && (r_cnt >= (cfg_sync_interval - 16'd1));
    w_bl_change = (in_local_blocklock != r_bl_copy);

    out_ready        = 1'b0;
    out_txdata_valid = 1'b0;
    out_syncing_pre  = 1'b0;
    out_txdata       = '0;

    unique case (r_state)
      ST_RUN: begin
        out_txdata       = r_buf;
        out_txdata_valid = r_buf_full;
        // Refuse new words when the transfer in flight completes the interval,
        // so the SYNC lands exactly after the last counted word.
        out_ready = (!r_buf_full || in_idle) &&
                    !(in_enable && (r_sync_req || (w_xfer && w_sync_due)));
      end
      ST_DRAIN: begin
        out_syncing_pre = 1'b1;
      end
      ST_SEND_SYNC: begin
        out_syncing_pre  = 1'b1;
        out_txdata_valid = 1'b1;
        out_txdata       = build_sync(r_bl_snap);
      end
      default: begin
        out_ready = 1'b0;
      end
    endcase

    w_acc = (r_state == ST_RUN) && in_data_valid && out_ready && in_enable;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_cnt      <= '0;
      r_sync_req <= 1'b1;
      r_bl_copy  <= '0;
      r_bl_snap  <= '0;
    end else if (in_enable) begin
      unique case (r_state)
        ST_RUN: begin
          r_bl_copy <= in_local_blocklock;
          if (w_acc) begin
            r_buf      <= in_data;
            r_buf_full <= 1'b1;
          end else if (w_xfer) begin
            r_buf_full <= 1'b0;
          end
          if (w_xfer) begin
            r_cnt <= r_cnt + 16'd1;
          end
          r_sync_req <= r_sync_req || (w_xfer && w_sync_due) || w_bl_change;
          if (r_sync_req && (!r_buf_full || w_xfer)) begin
            r_state   <= ST_DRAIN;
            r_bl_snap <= in_local_blocklock;
          end
        end
        ST_DRAIN: begin
          if (in_empty) begin
            r_state <= ST_SEND_SYNC;
          end
        end
        ST_SEND_SYNC: begin
          // Block-lock copy is frozen here; a change shows up as a new request in RUN.
          if (in_idle) begin
            r_state    <= ST_RUN;
            r_sync_req <= 1'b0;
            r_cnt      <= '0;
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_distributor.sv
// Scoreboard bench for tx_distributor: accepted words are queued and must
// re-emerge in order, with SYNC words of the expected content and spacing.
module tb_tx_distributor;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_enable;
  logic [191:0] in_data;
  logic         in_data_valid;
  logic         out_ready;
  logic [3:0]   in_local_blocklock;
  logic [15:0]  cfg_sync_interval;
  logic         in_idle;
  logic         in_empty;
  logic [191:0] out_txdata;
  logic         out_txdata_valid;
  logic         out_syncing_pre;

  tx_distributor dut (
    .clk                (clk),
    .reset              (reset),
    .in_enable          (in_enable),
    .in_data            (in_data),
    .in_data_valid      (in_data_valid),
    .out_ready          (out_ready),
    .in_local_blocklock (in_local_blocklock),
    .cfg_sync_interval  (cfg_sync_interval),
    .in_idle            (in_idle),
    .in_empty           (in_empty),
    .out_txdata         (out_txdata),
    .out_txdata_valid   (out_txdata_valid),
    .out_syncing_pre    (out_syncing_pre)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [191:0] sb[$];
  logic [3:0]   exp_bl;
  int           mon_ws = 0;
  int           sync_count = 0;
  int           acc_count = 0;
  bit           seen_sync = 0;
  int           ov_req = 0;
  int           ov_done = 0;
  int           ov_val = 0;

  function automatic logic [191:0] sync_word(input logic [3:0] bl);
    return {4{16'hB5A7, 28'h0, bl}};
  endfunction

  function automatic logic [191:0] rand192();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept observer: every word the DUT takes becomes an expected output.
  initial forever begin
    @(negedge clk);
    if (!reset && in_enable && in_data_valid && out_ready) begin
      sb.push_back(in_data);
      acc_count++;
    end
  end

  // Output monitor.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      sb.delete();
      seen_sync = 0;
      mon_ws = 0;
    end else if (in_enable && out_txdata_valid && in_idle) begin
      if (out_syncing_pre) begin
        chk("sync_word", out_txdata, sync_word(exp_bl));
        if (seen_sync && cfg_sync_interval != 16'd0) begin
          int exp_iv;
          exp_iv = int'(cfg_sync_interval);
          if (ov_req != ov_done) begin
            exp_iv = ov_val;
            ov_done = ov_req;
          end
          chk("sync_interval", 192'(mon_ws), 192'(exp_iv));
        end
        seen_sync = 1;
        mon_ws = 0;
        sync_count++;
      end else begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got %h, expected no word", out_txdata);
        end else begin
          logic [191:0] e;
          e = sb.pop_front();
          chk("data_word", out_txdata, e);
        end
        mon_ws++;
      end
    end
  end

  // One-entry holding register: never more than one word in flight.
  initial forever begin
    @(posedge clk);
    if (!reset && sb.size() > 1) begin
      n_tests++;
      n_fail++;
      $display("FAIL buf_overflow: got %0d words held, expected at most 1", sb.size());
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic drain();
    int c;
    in_enable = 1'b1; in_data_valid = 1'b0; in_idle = 1'b1; in_empty = 1'b1;
    c = 0;
    while (sb.size() != 0 && c < 200) begin step(); c++; end
    chk("drain_done", 192'(sb.size()), 192'(0));
    repeat (8) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_valid"}, 192'(out_txdata_valid), 192'(0));
    chk({tag, "_pre"},   192'(out_syncing_pre),  192'(0));
    chk({tag, "_data"},  out_txdata,             192'(0));
    chk({tag, "_ready"}, 192'(out_ready),        192'(1));
  endtask

  initial begin
    int c;
    int sc0;
    int a0;
    reset = 1'b1; in_enable = 1'b0; in_data = '0; in_data_valid = 1'b0;
    in_local_blocklock = 4'hF; exp_bl = 4'hF; cfg_sync_interval = 16'd0;
    in_idle = 1'b1; in_empty = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    check_reset_outputs("reset");

    // First enabled cycle: pending SYNC blocks upstream, then DRAIN, SYNC, RUN.
    step();
    in_enable = 1'b1;
    @(negedge clk);
    chk("boot_ready_low", 192'(out_ready), 192'(0));
    step();
    @(negedge clk);
    chk("boot_drain", 192'({out_syncing_pre, out_txdata_valid, out_ready}), 192'(3'b100));
    step();
    @(negedge clk);
    chk("boot_sync_flags", 192'({out_syncing_pre, out_txdata_valid}), 192'(2'b11));
    chk("boot_sync_word", out_txdata, sync_word(4'hF));
    step();
    @(negedge clk);
    chk("boot_ready_high", 192'({out_ready, out_syncing_pre}), 192'(2'b10));

    // Periodic SYNC every 4 words with continuous traffic.
    sc0 = sync_count;
    cfg_sync_interval = 16'd4;
    repeat (80) begin
      step();
      in_data = rand192(); in_data_valid = 1'b1; in_idle = 1'b1;
    end
    chk("periodic_sync_seen", 192'(sync_count - sc0 >= 8), 192'(1));
    drain();

    // Lower the interval mid-run while the counter is already past it.
    cfg_sync_interval = 16'd8;
    c = 0;
    while (c < 200) begin
      step();
      if (mon_ws == 5) begin
        in_idle = 1'b0; in_data_valid = 1'b0;
        break;
      end
      in_data = rand192(); in_data_valid = 1'b1; in_idle = 1'b1;
      c++;
    end
    chk("cfg_change_reached", 192'(c < 200), 192'(1));
    repeat (2) step();
    cfg_sync_interval = 16'd3;
    ov_val = 6;
    ov_req++;
    repeat (40) begin
      step();
      in_data = rand192(); in_data_valid = 1'b1; in_idle = 1'b1;
    end
    chk("cfg_override_used", 192'(ov_done), 192'(ov_req));
    drain();

    // Randomised traffic and handshakes, 1000 accepted words.
    cfg_sync_interval = 16'd5;
    a0 = acc_count;
    c = 0;
    while (acc_count - a0 < 1000 && c < 20000) begin
      step();
      in_data       = rand192();
      in_data_valid = ($urandom_range(0, 3) != 0);
      in_idle       = ($urandom_range(0, 1) != 0);
      in_empty      = ($urandom_range(0, 3) != 0);
      in_enable     = ($urandom_range(0, 7) != 0);
      c++;
    end
    chk("random_words_accepted", 192'(acc_count - a0 >= 1000), 192'(1));
    drain();

    // Block-lock change with periodic SYNC off: exactly one SYNC.
    cfg_sync_interval = 16'd0;
    sc0 = sync_count;
    in_local_blocklock = 4'h7; exp_bl = 4'h7;
    repeat (60) begin
      step();
      in_data = rand192(); in_data_valid = ($urandom_range(0, 1) != 0);
    end
    chk("bl_change_one_sync", 192'(sync_count - sc0), 192'(1));
    drain();

    // Swizzler not empty: distributor waits in DRAIN.
    in_empty = 1'b0;
    in_local_blocklock = 4'hE; exp_bl = 4'hE;
    c = 0;
    @(negedge clk);
    while (!out_syncing_pre && c < 20) begin step(); @(negedge clk); c++; end
    chk("drain_entered", 192'(out_syncing_pre), 192'(1));
    for (int i = 0; i < 20; i++) begin
      if (i != 0) begin step(); @(negedge clk); end
      chk("drain_hold", 192'({out_syncing_pre, out_txdata_valid, out_ready}), 192'(3'b100));
    end
    step();
    in_empty = 1'b1;
    @(negedge clk);
    chk("drain_still_no_valid", 192'(out_txdata_valid), 192'(0));
    step();
    @(negedge clk);
    chk("sync_after_empty", 192'({out_syncing_pre, out_txdata_valid}), 192'(2'b11));
    drain();

    // Reset while a SYNC is waiting for the swizzler.
    in_idle = 1'b0;
    in_local_blocklock = 4'h3; exp_bl = 4'h3;
    c = 0;
    @(negedge clk);
    while (!(out_syncing_pre && out_txdata_valid) && c < 20) begin step(); @(negedge clk); c++; end
    chk("send_sync_reached", 192'({out_syncing_pre, out_txdata_valid}), 192'(2'b11));
    step();
    reset = 1'b1; in_enable = 1'b0;
    step();
    reset = 1'b0;
    check_reset_outputs("midsync_reset");
    sc0 = sync_count;
    step();
    in_enable = 1'b1; in_idle = 1'b1; in_empty = 1'b1;
    c = 0;
    while (sync_count == sc0 && c < 20) begin step(); c++; end
    chk("post_reset_sync", 192'(sync_count - sc0), 192'(1));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
